progloader: RTL

- Writer side of the 1024x16 program memory: receives a program image as a byte stream and writes it word by word into program memory before the CPU runs.
- Sits between a byte source (UART receiver or test host) and the program memory write port.
- Holds the CPU in reset (cpu_run=0) until the image has loaded and its checksum has verified.

---
 rtl/progloader_pkg.sv | 16 +
 rtl/progloader_if.sv | 19 +
 rtl/progloader.sv | 95 +++++++++
 3 files changed

// File: rtl/progloader_pkg.sv
// progloader_pkg: shared program-memory geometry and loader state encodings.
package progloader_pkg;
    localparam int PM_AW = 10;
    localparam int PM_DW = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } pl_state_t;
endpackage

// File: rtl/progloader_if.sv
// progloader_if: byte stream in, program-memory write port and status out.
interface progloader_if import progloader_pkg::*; #(parameter int AW = PM_AW, parameter int DW = PM_DW);
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          busy;
    logic          done;
    logic          err;
    logic          cpu_run;

    modport master (output start, in_data, in_valid,
                    input  in_ready, we, wa, wd, busy, done, err, cpu_run);
    modport slave  (input  start, in_data, in_valid,
                    output in_ready, we, wa, wd, busy, done, err, cpu_run);
endinterface

// File: rtl/progloader.sv
// progloader: loads a counted, XOR-checksummed byte image into program memory
// and holds the CPU in reset until the image has verified.
module progloader import progloader_pkg::*; #(parameter int AW = PM_AW, parameter int DW = PM_DW) (
    input logic         clk,
    input logic         reset,
    progloader_if.slave bus
);
    localparam int unsigned DEPTH = 1 << AW;

    pl_state_t     state;
    logic [15:0]   cnt;
    logic [7:0]    chk;
    logic [7:0]    hi;
    logic [AW-1:0] idx;
    logic [15:0]   n;
    logic          acc;
    logic          last;

    assign bus.in_ready = state inside {S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO, S_CHK};
    assign bus.busy     = bus.in_ready;
    assign acc          = bus.in_ready && bus.in_valid;
    assign n            = {cnt[15:8], bus.in_data};
    assign last         = 16'(idx) == cnt - 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            chk         <= '0;
            hi          <= '0;
            idx         <= '0;
            bus.we      <= 1'b0;
            bus.wa      <= '0;
            bus.wd      <= '0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.cpu_run <= 1'b0;
        end else begin
            bus.we <= 1'b0;
            if (acc && state != S_CHK)
                chk <= chk ^ bus.in_data;
            case (state)
                S_IDLE, S_DONE, S_ERR:
                    if (bus.start) begin
                        state       <= S_CNT_HI;
                        chk         <= '0;
                        idx         <= '0;
                        bus.done    <= 1'b0;
                        bus.err     <= 1'b0;
                        bus.cpu_run <= 1'b0;
                    end
                S_CNT_HI:
                    if (acc) begin
                        cnt[15:8] <= bus.in_data;
                        state     <= S_CNT_LO;
                    end
                S_CNT_LO:
                    if (acc) begin
                        cnt <= n;
                        // Counts that would overflow the memory are rejected before any write.
                        if (n == 16'd0 || 32'(n) > DEPTH) begin
                            state   <= S_ERR;
                            bus.err <= 1'b1;
                        end else
                            state <= S_DAT_HI;
                    end
                S_DAT_HI:
                    if (acc) begin
                        hi    <= bus.in_data;
                        state <= S_DAT_LO;
                    end
                S_DAT_LO:
                    if (acc) begin
                        bus.we <= 1'b1;
                        bus.wa <= idx;
                        bus.wd <= DW'({hi, bus.in_data});
                        idx    <= idx + 1'b1;
                        state  <= last ? S_CHK : S_DAT_HI;
                    end
                S_CHK:
                    if (acc) begin
                        if (bus.in_data == chk) begin
                            state       <= S_DONE;
                            bus.done    <= 1'b1;
                            bus.cpu_run <= 1'b1;
                        end else begin
                            state   <= S_ERR;
                            bus.err <= 1'b1;
                        end
                    end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
